alu_issue: RTL and testbench
============================

# alu_issue

Operand-issue stage that sits directly upstream of the packed 4-bit-lane add/sub unit. It accepts 16-bit instructions through a valid/ready port and buffers them in a small FIFO. It holds a 4-entry × 8-bit register file, drives operands and opcode to the add/sub unit, waits for its done flag, and writes the packed result back to the destination register. Load-immediate and NOP are executed locally without using the add/sub unit.

## Interface
Parameters:
- FIFO_DEPTH, 2, instruction buffer depth; power of two, ≥2.
- MAX_WAIT, 15, cycles allowed in WAIT before timeout; ≥1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  equals !fifo_full; reset 0 while rst low, 1 after.
- instr  in  16  fields: [15:14] op, [13:12] rd, [11:10] rs1, [9:8] rs2, [7:0] imm.
- exe_in1  out  8  packed operand A = reg[rs1]; reset 0x00.
- exe_in2  out  8  packed operand B = reg[rs2]; reset 0x00.
- exe_op  out  2  0 = add, 1 = sub; reset 0.
- exe_start  out  1  high in ISSUE and WAIT (operands valid); reset 0.
- exe_done  in  1  result-valid flag from the add/sub unit.
- exe_result  in  8  packed result from the add/sub unit.
- rd_sel  in  2  debug read address.
- rd_data  out  8  combinational reg[rd_sel].
- busy  out  1  state != IDLE or FIFO non-empty; reset 0.
- timeout_err  out  1  sticky; cleared only by reset.

## Operation
- Op encoding: 00 ADD, 01 SUB, 10 LDI (reg[rd] <= imm), 11 NOP.
- Push: an instruction is accepted when instr_valid && instr_ready. If the FIFO is full, instr_ready is 0 and nothing is written. instr_ready depends only on full, so a simultaneous pop does not admit a push.
- FSM states: IDLE, ISSUE, WAIT.
  - IDLE, FIFO non-empty: pop the head.
    - ADD/SUB: register exe_in1 = reg[rs1], exe_in2 = reg[rs2], exe_op = op[0], latch rd, go to ISSUE.
    - LDI: write imm to reg[rd] at the end of this cycle and stay in IDLE.
    - NOP: discard and stay in IDLE.
  - ISSUE: one cycle; exe_done is ignored because it may be stale. Clear the wait counter and go to WAIT.
  - WAIT, exe_done = 1: write exe_result to reg[latched rd] and go to IDLE.
  - WAIT, exe_done = 0: increment the wait counter. When the counter reaches MAX_WAIT, set timeout_err, leave rd unchanged and go to IDLE.
- Operands and exe_op stay stable from ISSUE through the last WAIT cycle. In IDLE they hold their last value.
- Arithmetic: the block does none. Results are written verbatim; per-lane wrap-around belongs to the add/sub unit.
- Only one instruction is in flight at a time. Register hazards cannot occur because the writeback completes before the next pop reads the register file.
- rs1 == rs2 == rd is legal.
- Reset (any state, including mid-WAIT): FSM goes to IDLE, FIFO is emptied, all registers become 0x00, all outputs take their reset values, the wait counter clears and timeout_err clears. The in-flight instruction is lost.

## Timing
- An instruction pushed at cycle 0 into an empty FIFO with the FSM in IDLE:
  - pop at cycle 1;
  - ISSUE at cycle 2;
  - WAIT from cycle 3.
- exe_done seen high at cycle k ≥ 3 → the new value appears on rd_data at cycle k+1.
- Minimum ADD/SUB cost is 3 cycles per instruction; LDI and NOP cost 1 cycle each.
- A back-to-back LDI then ADD reading the same register sees the loaded value.
- Timeout fires on the MAX_WAIT-th WAIT cycle without exe_done. The FSM is in IDLE on the next cycle.

## Structure
- Shared package mini_core_pkg holds:
  - op encoding constants (OP_ADD, OP_SUB, OP_LDI, OP_NOP);
  - the FSM state encoding;
  - instr field bit-position constants;
  - REG_COUNT = 4.
- Sub-module instr_fifo: synchronous FIFO parameterised by depth and width. It has push/pop/full/empty, uses wrap-around pointers with an extra wrap bit, and takes the same clk/rst.
- The register file, FSM and wait counter live in alu_issue.

## Test plan
- Reset: assert rst mid-run → all outputs at reset values; rd_data = 0x00 for every rd_sel; busy = 0; timeout_err = 0.
- LDI/ADD: LDI r0 = 0x35, LDI r1 = 0x12, ADD r2 = r0 + r1; bench unit returns 0x47 two cycles after exe_start → exe_in1 = 0x35, exe_in2 = 0x12, exe_op = 0, rd_data(r2) = 0x47.
- SUB with self-operand: LDI r3 = 0x7F, SUB r3 = r3 - r3; bench returns 0x00 → exe_op = 1 and r3 = 0x00. The ISSUE cycle ignores a stale exe_done = 1.
- Backpressure, FIFO_DEPTH = 2: bench holds exe_done low and pushes 4 ADDs continuously → instr_ready goes 0 after the 3rd accept; no instruction is lost or duplicated after done is released.
- Timeout, MAX_WAIT = 15: exe_done is never asserted → timeout_err rises in the 15th WAIT cycle, rd is unchanged, the FSM returns to IDLE and the next LDI executes.
- Reset mid-WAIT: pulse rst low during WAIT with 1 instruction queued → FIFO empty, busy = 0, late exe_done/exe_result ignored, registers 0x00.

Source files
------------

// File: rtl/mini_core_pkg.sv
// Shared definitions for the mini core: opcode and FSM encodings, instruction
// field positions and a decode helper.
package mini_core_pkg;

   localparam int REG_COUNT = 4;
   localparam int INSTR_W   = 16;

   localparam int OP_HI  = 15;
   localparam int OP_LO  = 14;
   localparam int RD_HI  = 13;
   localparam int RD_LO  = 12;
   localparam int RS1_HI = 11;
   localparam int RS1_LO = 10;
   localparam int RS2_HI = 9;
   localparam int RS2_LO = 8;
   localparam int IMM_HI = 7;
   localparam int IMM_LO = 0;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_LDI = 2'b10,
      OP_NOP = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_ISSUE = 2'b01,
      ST_WAIT  = 2'b10
   } state_e;

   typedef struct packed {
      op_e        op;
      logic [1:0] rd;
      logic [1:0] rs1;
      logic [1:0] rs2;
      logic [7:0] imm;
   } instr_t;

   function automatic instr_t decode(input logic [INSTR_W-1:0] w);
      instr_t d;
      d.op  = op_e'(w[OP_HI:OP_LO]);
      d.rd  = w[RD_HI:RD_LO];
      d.rs1 = w[RS1_HI:RS1_LO];
      d.rs2 = w[RS2_HI:RS2_LO];
      d.imm = w[IMM_HI:IMM_LO];
      return d;
   endfunction

endpackage

// File: rtl/alu_issue_if.sv
// Instruction valid/ready port plus the operand/result link to the add/sub unit.
interface alu_issue_if;
   import mini_core_pkg::*;

   logic               instr_valid;
   logic               instr_ready;
   logic [INSTR_W-1:0] instr;
   logic [7:0]         exe_in1;
   logic [7:0]         exe_in2;
   logic [1:0]         exe_op;
   logic               exe_start;
   logic               exe_done;
   logic [7:0]         exe_result;

   // The issue stage is the slave: it receives instructions and results.
   modport slave (
      input  instr_valid, instr, exe_done, exe_result,
      output instr_ready, exe_in1, exe_in2, exe_op, exe_start
   );

   modport master (
      output instr_valid, instr, exe_done, exe_result,
      input  instr_ready, exe_in1, exe_in2, exe_op, exe_start
   );
endinterface

// File: rtl/instr_fifo.sv
// Synchronous FIFO with wrap-bit pointers; full/empty come straight from the
// pointer comparison so no occupancy counter is needed.
module instr_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push, do_pop;

   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

   // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
   end

   // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // NOTE: storage is not reset; resetting the pointers already makes every entry unreadable.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/alu_issue.sv
// Operand-issue stage: buffers instructions, reads the register file, hands
// ADD/SUB to the packed add/sub unit and writes back; LDI and NOP retire locally.
module alu_issue
   import mini_core_pkg::*;
#(
   parameter int FIFO_DEPTH = 2,
   parameter int MAX_WAIT   = 15
) (
   input  logic       clk,
   input  logic       rst,
   alu_issue_if.slave bus,
   input  logic [1:0] rd_sel,
   output logic [7:0] rd_data,
   output logic       busy,
   output logic       timeout_err
);
   localparam int WCW = $clog2(MAX_WAIT + 1);

   state_e         state_q, state_d;
   logic [7:0]     regs_q [REG_COUNT];
   logic [7:0]     regs_d [REG_COUNT];
   logic [7:0]     exe_in1_q, exe_in1_d;
   logic [7:0]     exe_in2_q, exe_in2_d;
   logic           exe_op_q, exe_op_d;
   logic [1:0]     rd_lat_q, rd_lat_d;
   logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
   logic           timeout_q, timeout_d;

   logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [INSTR_W-1:0] fifo_rdata;
   instr_t             head;
   logic               head_is_alu, wait_last, timeout_hit;

   // Ready depends only on full (and reset), never on a same-cycle pop.
   assign bus.instr_ready = rst && !fifo_full;
   assign fifo_push       = bus.instr_valid && bus.instr_ready;
   assign head            = decode(fifo_rdata);
   assign head_is_alu     = (head.op == OP_ADD) || (head.op == OP_SUB);
   assign wait_last       = (wait_cnt_q == WCW'(MAX_WAIT - 1));
   assign timeout_hit     = (state_q == ST_WAIT) && !bus.exe_done && wait_last;

   instr_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(INSTR_W)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .wdata (bus.instr),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         regs_q     <= '{default: '0};
         exe_in1_q  <= '0;
         exe_in2_q  <= '0;
         exe_op_q   <= 1'b0;
         rd_lat_q   <= '0;
         wait_cnt_q <= '0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         regs_q     <= regs_d;
         exe_in1_q  <= exe_in1_d;
         exe_in2_q  <= exe_in2_d;
         exe_op_q   <= exe_op_d;
         rd_lat_q   <= rd_lat_d;
         wait_cnt_q <= wait_cnt_d;
         timeout_q  <= timeout_d;
      end
   end

   always_comb begin : next_state
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (!fifo_empty && head_is_alu) state_d = ST_ISSUE;
         ST_ISSUE: state_d = ST_WAIT;
         ST_WAIT:  if (bus.exe_done || wait_last) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin : datapath
      fifo_pop   = 1'b0;
      regs_d     = regs_q;
      exe_in1_d  = exe_in1_q;
      exe_in2_d  = exe_in2_q;
      exe_op_d   = exe_op_q;
      rd_lat_d   = rd_lat_q;
      wait_cnt_d = wait_cnt_q;
      timeout_d  = timeout_q;
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               if (head_is_alu) begin
                  exe_in1_d = regs_q[head.rs1];
                  exe_in2_d = regs_q[head.rs2];
                  exe_op_d  = (head.op == OP_SUB);
                  rd_lat_d  = head.rd;
               end else if (head.op == OP_LDI) begin
                  regs_d[head.rd] = head.imm;
               end
            end
         end
         // A done seen during ISSUE may belong to the previous operation.
         ST_ISSUE: wait_cnt_d = '0;
         ST_WAIT: begin
            if (bus.exe_done) begin
               regs_d[rd_lat_q] = bus.exe_result;
            end else begin
               wait_cnt_d = wait_cnt_q + 1'b1;
               if (wait_last) timeout_d = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_comb begin : outputs
      bus.exe_in1   = exe_in1_q;
      bus.exe_in2   = exe_in2_q;
      bus.exe_op    = {1'b0, exe_op_q};
      bus.exe_start = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
      busy          = (state_q != ST_IDLE) || !fifo_empty;
      timeout_err   = timeout_q || timeout_hit;
      rd_data       = regs_q[rd_sel];
   end

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a small packed add/sub unit model.
module tb_alu_issue;
   localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, LDI = 2'b10;

   logic       clk, rst;
   logic [1:0] rd_sel;
   logic [7:0] rd_data;
   logic       busy, timeout_err;

   alu_issue_if bus();

   alu_issue #(.FIFO_DEPTH(2), .MAX_WAIT(15)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .rd_sel      (rd_sel),
      .rd_data     (rd_data),
      .busy        (busy),
      .timeout_err (timeout_err)
   );

   int         tests_run = 0;
   int         tests_failed = 0;
   logic       unit_hold, force_done, model_done;
   logic [7:0] force_result, model_result;
   int         run_cnt, issue_cnt;

   assign bus.exe_done   = model_done | force_done;
   assign bus.exe_result = force_done ? force_result : model_result;

   initial begin
      clk = 1'b0;
      forever #10 clk = ~clk;
   end

   function automatic logic [15:0] enc(input logic [1:0] op, input logic [1:0] rd,
                                       input logic [1:0] rs1, input logic [1:0] rs2,
                                       input logic [7:0] imm);
      return {op, rd, rs1, rs2, imm};
   endfunction

   function automatic logic [7:0] lane_op(input logic [7:0] a, input logic [7:0] b, input logic sub);
      logic [3:0] hi, lo;
      hi = sub ? a[7:4] - b[7:4] : a[7:4] + b[7:4];
      lo = sub ? a[3:0] - b[3:0] : a[3:0] + b[3:0];
      return {hi, lo};
   endfunction

   // Add/sub unit: answers on the third cycle of exe_start unless held off.
   initial begin
      model_done   = 1'b0;
      model_result = '0;
      run_cnt      = 0;
      issue_cnt    = 0;
      forever begin
         @(negedge clk);
         if (bus.exe_start) run_cnt++;
         else run_cnt = 0;
         if (run_cnt == 1) issue_cnt++;
         model_done   = bus.exe_start && (run_cnt >= 3) && !unit_hold;
         model_result = lane_op(bus.exe_in1, bus.exe_in2, bus.exe_op[0]);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, tests_run=%0d", tests_run);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic read_reg(input logic [1:0] s, output logic [7:0] v);
      rd_sel = s;
      #1;
      v = rd_data;
   endtask

   task automatic push_one(input logic [15:0] w);
      int guard = 0;
      bus.instr_valid = 1'b1;
      bus.instr       = w;
      while (!bus.instr_ready && guard < 60) begin
         tick();
         guard++;
      end
      tests_run++;
      if (bus.instr_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL push_ready: instr_ready=%b after %0d cycles, required 1", bus.instr_ready, guard);
      end
      tick();
      bus.instr_valid = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int guard = 0;
      while (busy && guard < 200) begin
         tick();
         guard++;
      end
      tests_run++;
      if (busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL %s_idle: busy=%b after %0d cycles, required 0", name, busy, guard);
      end
   endtask

   task automatic test_ldi_add();
      logic [7:0] v;
      push_one(enc(LDI, 2'd0, 2'd0, 2'd0, 8'h35));
      push_one(enc(LDI, 2'd1, 2'd0, 2'd0, 8'h12));
      push_one(enc(ADD, 2'd2, 2'd0, 2'd1, 8'h00));
      tick();
      tests_run++;
      if ({bus.exe_start, bus.exe_in1, bus.exe_in2, bus.exe_op} !== {1'b1, 8'h35, 8'h12, 2'd0}) begin
         tests_failed++;
         $display("FAIL add_issue: start/in1/in2/op=%b/%h/%h/%0d, required 1/35/12/0",
                  bus.exe_start, bus.exe_in1, bus.exe_in2, bus.exe_op);
      end
      tick();
      tick();
      read_reg(2'd2, v);
      tests_run++;
      if ({bus.exe_in1, v} !== {8'h35, 8'h00}) begin
         tests_failed++;
         $display("FAIL add_before_done: in1=%h r2=%h, required 35 00", bus.exe_in1, v);
      end
      tick();
      read_reg(2'd2, v);
      tests_run++;
      if ({v, busy} !== {8'h47, 1'b0}) begin
         tests_failed++;
         $display("FAIL add_writeback: r2=%h busy=%b, required 47 0", v, busy);
      end
   endtask

   task automatic test_sub_self();
      logic [7:0] v;
      push_one(enc(LDI, 2'd3, 2'd0, 2'd0, 8'h7F));
      push_one(enc(SUB, 2'd3, 2'd3, 2'd3, 8'h00));
      tick();
      tests_run++;
      if ({bus.exe_start, bus.exe_in1, bus.exe_in2, bus.exe_op} !== {1'b1, 8'h7F, 8'h7F, 2'd1}) begin
         tests_failed++;
         $display("FAIL sub_issue: start/in1/in2/op=%b/%h/%h/%0d, required 1/7f/7f/1",
                  bus.exe_start, bus.exe_in1, bus.exe_in2, bus.exe_op);
      end
      force_result = 8'hEE;
      force_done   = 1'b1;
      tick();
      force_done = 1'b0;
      read_reg(2'd3, v);
      tests_run++;
      if ({v, bus.exe_start} !== {8'h7F, 1'b1}) begin
         tests_failed++;
         $display("FAIL sub_stale_done: r3=%h start=%b, required 7f 1", v, bus.exe_start);
      end
      wait_idle("sub");
      read_reg(2'd3, v);
      tests_run++;
      if (v !== 8'h00) begin
         tests_failed++;
         $display("FAIL sub_writeback: r3=%h, required 00", v);
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] v2, v3;
      int base;
      push_one(enc(LDI, 2'd0, 2'd0, 2'd0, 8'h01));
      push_one(enc(LDI, 2'd1, 2'd0, 2'd0, 8'h02));
      wait_idle("bp_setup");
      base      = issue_cnt;
      unit_hold = 1'b1;
      push_one(enc(ADD, 2'd2, 2'd0, 2'd1, 8'h00));
      push_one(enc(ADD, 2'd2, 2'd2, 2'd1, 8'h00));
      tests_run++;
      if (bus.instr_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL bp_ready_2nd: instr_ready=%b, required 1", bus.instr_ready);
      end
      push_one(enc(ADD, 2'd2, 2'd2, 2'd1, 8'h00));
      tests_run++;
      if (bus.instr_ready !== 1'b0) begin
         tests_failed++;
         $display("FAIL bp_ready_3rd: instr_ready=%b, required 0", bus.instr_ready);
      end
      repeat (4) tick();
      tests_run++;
      if (bus.instr_ready !== 1'b0) begin
         tests_failed++;
         $display("FAIL bp_ready_held: instr_ready=%b, required 0", bus.instr_ready);
      end
      unit_hold = 1'b0;
      push_one(enc(ADD, 2'd3, 2'd2, 2'd0, 8'h00));
      wait_idle("bp");
      read_reg(2'd2, v2);
      read_reg(2'd3, v3);
      tests_run++;
      if ({v2, v3, timeout_err} !== {8'h07, 8'h08, 1'b0} || issue_cnt - base != 4) begin
         tests_failed++;
         $display("FAIL bp_results: r2=%h r3=%h tmo=%b issues=%0d, required 07 08 0 4",
                  v2, v3, timeout_err, issue_cnt - base);
      end
   endtask

   task automatic test_timeout();
      logic [7:0] v;
      unit_hold = 1'b1;
      push_one(enc(ADD, 2'd1, 2'd0, 2'd2, 8'h00));
      repeat (15) tick();
      tests_run++;
      if ({timeout_err, bus.exe_start} !== 2'b01) begin
         tests_failed++;
         $display("FAIL tmo_wait14: tmo=%b start=%b, required 0 1", timeout_err, bus.exe_start);
      end
      tick();
      tests_run++;
      if ({timeout_err, bus.exe_start} !== 2'b11) begin
         tests_failed++;
         $display("FAIL tmo_wait15: tmo=%b start=%b, required 1 1", timeout_err, bus.exe_start);
      end
      tick();
      read_reg(2'd1, v);
      tests_run++;
      if ({timeout_err, bus.exe_start, busy, v} !== {1'b1, 1'b0, 1'b0, 8'h02}) begin
         tests_failed++;
         $display("FAIL tmo_idle: tmo=%b start=%b busy=%b r1=%h, required 1 0 0 02",
                  timeout_err, bus.exe_start, busy, v);
      end
      unit_hold = 1'b0;
      push_one(enc(LDI, 2'd1, 2'd0, 2'd0, 8'h99));
      wait_idle("tmo_ldi");
      read_reg(2'd1, v);
      tests_run++;
      if ({v, timeout_err} !== {8'h99, 1'b1}) begin
         tests_failed++;
         $display("FAIL tmo_next_ldi: r1=%h tmo=%b, required 99 1", v, timeout_err);
      end
   endtask

   task automatic test_reset();
      logic [7:0] v;
      push_one(enc(LDI, 2'd0, 2'd0, 2'd0, 8'h5C));
      wait_idle("rst_setup");
      rst = 1'b0;
      #1;
      tests_run++;
      if ({bus.instr_ready, busy, timeout_err, bus.exe_start, bus.exe_in1, bus.exe_in2, bus.exe_op}
          !== {4'b0000, 8'h00, 8'h00, 2'd0}) begin
         tests_failed++;
         $display("FAIL rst_outputs: rdy/busy/tmo/start=%b%b%b%b in1=%h in2=%h op=%0d, required 0000 00 00 0",
                  bus.instr_ready, busy, timeout_err, bus.exe_start, bus.exe_in1, bus.exe_in2, bus.exe_op);
      end
      for (int s = 0; s < 4; s++) begin
         read_reg(s[1:0], v);
         tests_run++;
         if (v !== 8'h00) begin
            tests_failed++;
            $display("FAIL rst_reg%0d: rd_data=%h, required 00", s, v);
         end
      end
      tick();
      rst = 1'b1;
      tick();
      tests_run++;
      if (bus.instr_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL rst_release_ready: instr_ready=%b, required 1", bus.instr_ready);
      end
   endtask

   task automatic test_reset_mid_wait();
      logic [7:0] v;
      push_one(enc(LDI, 2'd0, 2'd0, 2'd0, 8'h21));
      wait_idle("rmw_setup");
      unit_hold = 1'b1;
      push_one(enc(ADD, 2'd2, 2'd0, 2'd0, 8'h00));
      push_one(enc(LDI, 2'd3, 2'd0, 2'd0, 8'h44));
      tick();
      tests_run++;
      if ({bus.exe_start, busy} !== 2'b11) begin
         tests_failed++;
         $display("FAIL rmw_in_wait: start=%b busy=%b, required 1 1", bus.exe_start, busy);
      end
      rst = 1'b0;
      #1;
      tests_run++;
      if ({bus.exe_start, busy, bus.instr_ready} !== 3'b000) begin
         tests_failed++;
         $display("FAIL rmw_async: start=%b busy=%b rdy=%b, required 0 0 0", bus.exe_start, busy, bus.instr_ready);
      end
      force_result = 8'hC3;
      force_done   = 1'b1;
      tick();
      rst = 1'b1;
      tick();
      tick();
      force_done = 1'b0;
      unit_hold  = 1'b0;
      tests_run++;
      if ({busy, bus.instr_ready, timeout_err} !== 3'b010) begin
         tests_failed++;
         $display("FAIL rmw_after: busy=%b rdy=%b tmo=%b, required 0 1 0", busy, bus.instr_ready, timeout_err);
      end
      for (int s = 0; s < 4; s++) begin
         read_reg(s[1:0], v);
         tests_run++;
         if (v !== 8'h00) begin
            tests_failed++;
            $display("FAIL rmw_reg%0d: rd_data=%h, required 00", s, v);
         end
      end
   endtask

   initial begin
      rst             = 1'b0;
      rd_sel          = 2'd0;
      unit_hold       = 1'b0;
      force_done      = 1'b0;
      force_result    = 8'h00;
      bus.instr_valid = 1'b0;
      bus.instr       = '0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      test_ldi_add();
      test_sub_self();
      test_backpressure();
      test_timeout();
      test_reset();
      test_reset_mid_wait();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
